// File: rtl/dfs_freq_actuator_if.sv
// rtl/dfs_freq_actuator_if.sv - controller, clock-generator and status signals of the DFS actuator
interface dfs_freq_actuator_if #(
  parameter int DATA_WIDTH = 13
);
  logic                  req_en_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic                  ack_o;
  logic                  cg_wr_o;
  logic [DATA_WIDTH-1:0] cg_freq_o;
  logic                  cg_locked_i;
  logic [DATA_WIDTH-1:0] cur_freq_o;
  logic                  busy_o;
  logic                  err_o;
  logic [15:0]           stat_changes_o;
  logic [15:0]           stat_timeouts_o;

  modport slave (
    input  req_en_i, req_data_i, cg_locked_i,
    output ack_o, cg_wr_o, cg_freq_o, cur_freq_o, busy_o, err_o,
           stat_changes_o, stat_timeouts_o
  );

  modport master (
    output req_en_i, req_data_i, cg_locked_i,
    input  ack_o, cg_wr_o, cg_freq_o, cur_freq_o, busy_o, err_o,
           stat_changes_o, stat_timeouts_o
  );
endinterface

// File: rtl/dfs_freq_actuator.sv
// rtl/dfs_freq_actuator.sv - clamps frequency requests, programs the clock generator, waits for relock
// Optional statistics counters are built only when DFS_ACTUATOR_STATS_EN is defined.
module dfs_freq_actuator #(
  parameter int DATA_WIDTH   = 13,
  parameter int FREQ_MIN     = 280,
  parameter int FREQ_MAX     = 480,
  parameter int RESET_FREQ   = 440,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dfs_freq_actuator_if.slave   bus
);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] L_MIN   = DATA_WIDTH'(FREQ_MIN);
  localparam logic [DATA_WIDTH-1:0] L_MAX   = DATA_WIDTH'(FREQ_MAX);
  localparam logic [DATA_WIDTH-1:0] L_RESET = DATA_WIDTH'(RESET_FREQ);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_PROGRAM, S_WAIT_UNLOCK, S_WAIT_LOCK, S_ACK
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_target;
  logic [DATA_WIDTH-1:0] r_cur_freq;
  logic [DATA_WIDTH-1:0] r_cg_freq;
  logic                  r_pend_valid;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic [TW-1:0]         r_tcnt;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] w_clamped;
  logic                  w_tmo;
  logic                  w_inc_change;
  logic                  w_inc_tmo;

  assign w_clamped = (r_target < L_MIN) ? L_MIN :
                     (r_target > L_MAX) ? L_MAX : r_target;
  assign w_tmo     = (r_tcnt == TW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_inc_change = 1'b0;
    w_inc_tmo    = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.req_en_i) w_next = S_CHECK;
      S_CHECK:   w_next = (w_clamped == r_cur_freq) ? S_ACK : S_PROGRAM;
      S_PROGRAM: w_next = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: begin
        if (w_tmo) begin
          w_next    = S_ACK;
          w_inc_tmo = 1'b1;
        end else if (!bus.cg_locked_i || r_tcnt == TW'(7)) begin
          w_next = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (bus.cg_locked_i) begin
          w_next       = S_ACK;
          w_inc_change = 1'b1;
        end else if (w_tmo) begin
          w_next    = S_ACK;
          w_inc_tmo = 1'b1;
        end
      end
      S_ACK:   w_next = (r_pend_valid || bus.req_en_i) ? S_CHECK : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A strobe coinciding with ack is consumed directly, so it wins over an older pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target     <= L_RESET;
      r_cur_freq   <= L_RESET;
      r_cg_freq    <= L_RESET;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_tcnt       <= '0;
      r_err        <= 1'b0;
    end else begin
      if (r_state inside {S_WAIT_UNLOCK, S_WAIT_LOCK}) r_tcnt <= r_tcnt + TW'(1);
      else                                             r_tcnt <= '0;
      case (r_state)
        S_IDLE: if (bus.req_en_i) r_target <= bus.req_data_i;
        S_CHECK: begin
          r_target <= w_clamped;
          if (w_next == S_PROGRAM) r_cg_freq <= w_clamped;
        end
        S_ACK: begin
          if (bus.req_en_i)      r_target <= bus.req_data_i;
          else if (r_pend_valid) r_target <= r_pend_data;
        end
        default: ;
      endcase
      if (r_state == S_ACK) begin
        r_pend_valid <= 1'b0;
      end else if (r_state != S_IDLE && bus.req_en_i) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= bus.req_data_i;
      end
      if (w_inc_change) r_cur_freq <= r_target;
      if (w_inc_tmo)    r_err      <= 1'b1;
    end
  end

`ifdef DFS_ACTUATOR_STATS_EN
  logic [15:0] r_stat_changes;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_changes  <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_inc_change && r_stat_changes != 16'hFFFF)  r_stat_changes  <= r_stat_changes + 16'd1;
      if (w_inc_tmo && r_stat_timeouts != 16'hFFFF)    r_stat_timeouts <= r_stat_timeouts + 16'd1;
    end
  end

  assign bus.stat_changes_o  = r_stat_changes;
  assign bus.stat_timeouts_o = r_stat_timeouts;
`else
  assign bus.stat_changes_o  = 16'd0;
  assign bus.stat_timeouts_o = 16'd0;
`endif

  assign bus.ack_o      = (r_state == S_ACK);
  assign bus.cg_wr_o    = (r_state == S_PROGRAM);
  assign bus.busy_o     = (r_state != S_IDLE);
  assign bus.cg_freq_o  = r_cg_freq;
  assign bus.cur_freq_o = r_cur_freq;
  assign bus.err_o      = r_err;
endmodule

// File: tb/tb_dfs_freq_actuator.sv
// tb/tb_dfs_freq_actuator.sv - randomized self-checking bench for dfs_freq_actuator
// Expected statistics follow DFS_ACTUATOR_STATS_EN when it is defined for the build.
module tb_dfs_freq_actuator;
  localparam int DW = 13;
`ifdef DFS_ACTUATOR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dfs_freq_actuator_if #(.DATA_WIDTH(DW)) dif ();
  dfs_freq_actuator #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ack_cnt = 0, wr_cnt = 0, ack_cyc = 0, wr_cyc = 0, req_cyc = 0;
  logic [DW-1:0] last_wr = '0;
  int lk_cnt = 0, low_len = 10;
  bit hold_low = 1'b0;
  int m_cur = 440, m_chg = 0, m_tmo = 0;

  always @(posedge clk) cyc++;

  // Clock-generator model: lock drops one cycle after a program strobe for low_len cycles.
  always @(negedge clk) begin
    if (dif.ack_o) begin ack_cnt++; ack_cyc = cyc; end
    if (dif.cg_wr_o) begin wr_cnt++; wr_cyc = cyc; last_wr = dif.cg_freq_o; end
    if (!rst_n) begin
      lk_cnt = 0;
      dif.cg_locked_i = 1'b1;
    end else if (hold_low) begin
      dif.cg_locked_i = 1'b0;
    end else if (lk_cnt > 0) begin
      lk_cnt++;
      if (lk_cnt >= 2 + low_len) begin
        dif.cg_locked_i = 1'b1;
        lk_cnt = 0;
      end else begin
        dif.cg_locked_i = (lk_cnt < 2);
      end
    end else begin
      dif.cg_locked_i = 1'b1;
      if (dif.cg_wr_o) lk_cnt = 1;
    end
  end

  function automatic int clamp(input int d);
    return (d < 280) ? 280 : (d > 480) ? 480 : d;
  endfunction

  function automatic int exp_stat(input int v);
    return STATS_ON ? ((v > 65535) ? 65535 : v) : 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    hold_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_cur = 440; m_chg = 0; m_tmo = 0;
  endtask

  task automatic send_req(input logic [DW-1:0] d);
    @(posedge clk); #1;
    dif.req_en_i = 1'b1; dif.req_data_i = d; req_cyc = cyc;
    @(posedge clk); #1;
    dif.req_en_i = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      if (ack_cnt >= target) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic apply_req(input int d, input int low, output int acks, output int wrs, output bit ok);
    int a0, w0;
    a0 = ack_cnt; w0 = wr_cnt; low_len = low;
    send_req(d[DW-1:0]);
    wait_acks(a0 + 1, 2000, ok);
    repeat (4) @(negedge clk);
    acks = ack_cnt - a0; wrs = wr_cnt - w0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (dif.cur_freq_o !== 13'd440) begin n_bad++; $display("FAIL reset_cur: got %0d expected 440", dif.cur_freq_o); end
    n_cmp++; if (dif.cg_freq_o !== 13'd440) begin n_bad++; $display("FAIL reset_cg_freq: got %0d expected 440", dif.cg_freq_o); end
    n_cmp++; if ({dif.ack_o, dif.cg_wr_o, dif.busy_o, dif.err_o} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b expected 0000", {dif.ack_o, dif.cg_wr_o, dif.busy_o, dif.err_o}); end
    n_cmp++; if ({dif.stat_changes_o, dif.stat_timeouts_o} !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", dif.stat_changes_o, dif.stat_timeouts_o); end
  endtask

  task automatic test_basic();
    int acks, wrs; bit ok;
    apply_req(400, 10, acks, wrs, ok);
    m_cur = 400; m_chg++;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_ack_wait: got timeout expected ack"); end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL basic_acks: got %0d expected 1", acks); end
    n_cmp++; if (wrs != 1) begin n_bad++; $display("FAIL basic_writes: got %0d expected 1", wrs); end
    n_cmp++; if (last_wr !== 13'd400) begin n_bad++; $display("FAIL basic_cg_freq: got %0d expected 400", last_wr); end
    n_cmp++; if (dif.cur_freq_o !== 13'd400) begin n_bad++; $display("FAIL basic_cur: got %0d expected 400", dif.cur_freq_o); end
    n_cmp++; if (dif.stat_changes_o !== 16'(exp_stat(m_chg))) begin n_bad++; $display("FAIL basic_stat: got %0d expected %0d", dif.stat_changes_o, exp_stat(m_chg)); end
  endtask

  task automatic test_clamp();
    int reqs[2] = '{600, 100};
    int acks, wrs, c; bit ok;
    foreach (reqs[k]) begin
      apply_req(reqs[k], $urandom_range(0, 12), acks, wrs, ok);
      c = clamp(reqs[k]);
      n_cmp++; if (!ok || acks != 1) begin n_bad++; $display("FAIL clamp_acks req %0d: got %0d expected 1", reqs[k], acks); end
      n_cmp++; if (wrs != 1 || last_wr !== DW'(c)) begin n_bad++; $display("FAIL clamp_cg_freq req %0d: got %0d (writes %0d) expected %0d", reqs[k], last_wr, wrs, c); end
      n_cmp++; if (dif.cur_freq_o !== DW'(c)) begin n_bad++; $display("FAIL clamp_cur req %0d: got %0d expected %0d", reqs[k], dif.cur_freq_o, c); end
      m_cur = c; m_chg++;
    end
  endtask

  task automatic test_same_freq();
    int acks, wrs; bit ok;
    do_reset();
    apply_req(440, 10, acks, wrs, ok);
    n_cmp++; if (!ok || acks != 1) begin n_bad++; $display("FAIL same_acks: got %0d expected 1", acks); end
    n_cmp++; if (wrs != 0) begin n_bad++; $display("FAIL same_writes: got %0d expected 0", wrs); end
    n_cmp++; if (ack_cyc - req_cyc > 3) begin n_bad++; $display("FAIL same_latency: got %0d expected <=3", ack_cyc - req_cyc); end
    n_cmp++; if (dif.stat_changes_o !== 16'd0) begin n_bad++; $display("FAIL same_stat: got %0d expected 0", dif.stat_changes_o); end
  endtask

  task automatic test_pending();
    int a0, w0; bit ok;
    a0 = ack_cnt; w0 = wr_cnt; low_len = 10;
    send_req(13'd420);
    send_req(13'd360);
    send_req(13'd380);
    wait_acks(a0 + 2, 500, ok);
    repeat (30) @(negedge clk);
    m_cur = 380; m_chg += 2;
    n_cmp++; if (!ok || ack_cnt - a0 != 2) begin n_bad++; $display("FAIL pend_acks: got %0d expected 2", ack_cnt - a0); end
    n_cmp++; if (wr_cnt - w0 != 2) begin n_bad++; $display("FAIL pend_writes: got %0d expected 2", wr_cnt - w0); end
    n_cmp++; if (last_wr !== 13'd380 || dif.cur_freq_o !== 13'd380) begin n_bad++; $display("FAIL pend_freq: got %0d/%0d expected 380/380", last_wr, dif.cur_freq_o); end
  endtask

  task automatic test_timeout();
    int a0, w0; bit ok;
    a0 = ack_cnt; w0 = wr_cnt; hold_low = 1'b1;
    send_req(13'd320);
    for (int i = 0; i < 20 && wr_cnt == w0; i++) @(negedge clk);
    repeat (1000) @(negedge clk);
    n_cmp++; if (dif.err_o !== 1'b0 || ack_cnt != a0) begin n_bad++; $display("FAIL tmo_early: got err %b acks %0d expected 0/0", dif.err_o, ack_cnt - a0); end
    wait_acks(a0 + 1, 100, ok);
    repeat (3) @(negedge clk);
    m_tmo++;
    n_cmp++; if (!ok || ack_cnt - a0 != 1) begin n_bad++; $display("FAIL tmo_acks: got %0d expected 1", ack_cnt - a0); end
    n_cmp++; if (dif.err_o !== 1'b1) begin n_bad++; $display("FAIL tmo_err: got %b expected 1", dif.err_o); end
    n_cmp++; if (ack_cyc - wr_cyc < 1020 || ack_cyc - wr_cyc > 1030) begin n_bad++; $display("FAIL tmo_time: got %0d expected about 1025", ack_cyc - wr_cyc); end
    n_cmp++; if (dif.cur_freq_o !== DW'(m_cur)) begin n_bad++; $display("FAIL tmo_cur: got %0d expected %0d", dif.cur_freq_o, m_cur); end
    n_cmp++; if (dif.stat_timeouts_o !== 16'(exp_stat(m_tmo))) begin n_bad++; $display("FAIL tmo_stat: got %0d expected %0d", dif.stat_timeouts_o, exp_stat(m_tmo)); end
    hold_low = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a0;
    a0 = ack_cnt; low_len = 60;
    send_req(13'd300);
    for (int i = 0; i < 60 && lk_cnt < 6; i++) @(negedge clk);
    n_cmp++; if (dif.busy_o !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b expected 1", dif.busy_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dif.busy_o !== 1'b0 || dif.ack_o !== 1'b0 || dif.err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_flags: got busy %b ack %b err %b expected 0", dif.busy_o, dif.ack_o, dif.err_o); end
    n_cmp++; if (dif.cur_freq_o !== 13'd440) begin n_bad++; $display("FAIL rmid_cur: got %0d expected 440", dif.cur_freq_o); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    m_cur = 440; m_chg = 0; m_tmo = 0;
    n_cmp++; if (ack_cnt != a0) begin n_bad++; $display("FAIL rmid_no_ack: got %0d expected 0", ack_cnt - a0); end
  endtask

  task automatic test_random();
    int acks, wrs, c, d; bit ok, w;
    for (int n = 0; n < 25; n++) begin
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8191) : $urandom_range(200, 560);
      apply_req(d, $urandom_range(0, 20), acks, wrs, ok);
      c = clamp(d);
      w = (c != m_cur);
      n_cmp++; if (!ok || acks != 1) begin n_bad++; $display("FAIL rand_acks req %0d: got %0d expected 1", d, acks); end
      n_cmp++; if (wrs != int'(w)) begin n_bad++; $display("FAIL rand_writes req %0d: got %0d expected %0d", d, wrs, w); end
      if (w) begin
        n_cmp++; if (last_wr !== DW'(c)) begin n_bad++; $display("FAIL rand_cg_freq req %0d: got %0d expected %0d", d, last_wr, c); end
        m_chg++;
      end
      m_cur = c;
      n_cmp++; if (dif.cur_freq_o !== DW'(c)) begin n_bad++; $display("FAIL rand_cur req %0d: got %0d expected %0d", d, dif.cur_freq_o, c); end
    end
    n_cmp++; if (dif.stat_changes_o !== 16'(exp_stat(m_chg)) || dif.err_o !== 1'b0) begin n_bad++; $display("FAIL rand_stat: got %0d err %b expected %0d err 0", dif.stat_changes_o, dif.err_o, exp_stat(m_chg)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.req_en_i = 1'b0;
    dif.req_data_i = '0;
    test_reset();
    test_basic();
    test_clamp();
    test_same_freq();
    test_pending();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dfs_freq_actuator.md
DFS_FREQ_ACTUATOR -- requirements
Module: dfs_freq_actuator

Interface
REQ-001 Parameter DATA_WIDTH, default 13, shall set the frequency-word width.
REQ-002 Parameter FREQ_MIN, default 280, shall set the lowest accepted frequency word.
REQ-003 Parameter FREQ_MAX, default 480, shall set the highest accepted frequency word.
REQ-004 Parameter RESET_FREQ, default 440, shall set the frequency word applied out of reset.
REQ-005 Parameter LOCK_TIMEOUT, default 1024, shall set the maximum number of cycles to wait for clock-generator lock.
REQ-006 Ports shall be:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_en_i  in  1  one-cycle frequency-request strobe from the controller
- req_data_i  in  DATA_WIDTH  requested frequency word, valid with req_en_i
- ack_o  out  1  one-cycle completion pulse to the controller
- cg_wr_o  out  1  one-cycle program strobe to the clock generator
- cg_freq_o  out  DATA_WIDTH  word driven to the clock generator, valid with cg_wr_o
- cg_locked_i  in  1  clock-generator lock status
- cur_freq_o  out  DATA_WIDTH  currently applied frequency word
- busy_o  out  1  high whenever the FSM is not in S_IDLE
- err_o  out  1  sticky lock-timeout flag
- stat_changes_o  out  16  count of completed frequency changes
- stat_timeouts_o  out  16  count of lock timeouts

Function
REQ-007 The FSM shall have states S_IDLE, S_CHECK, S_PROGRAM, S_WAIT_UNLOCK, S_WAIT_LOCK and S_ACK.
REQ-008 In S_IDLE, req_en_i=1 shall capture req_data_i into a target register and move the FSM to S_CHECK on the next cycle.
REQ-009 In S_CHECK, a target below FREQ_MIN shall be clamped to FREQ_MIN, and a target above FREQ_MAX shall be clamped to FREQ_MAX.
REQ-010 In S_CHECK, a clamped target equal to cur_freq_o shall go directly to S_ACK; any other value shall go to S_PROGRAM.
REQ-011 S_PROGRAM shall assert cg_wr_o for exactly one cycle with cg_freq_o equal to the clamped target, then move to S_WAIT_UNLOCK.
REQ-012 S_WAIT_UNLOCK shall move to S_WAIT_LOCK when cg_locked_i=0, or after 8 cycles if lock never drops.
REQ-013 S_WAIT_LOCK shall move to S_ACK on cg_locked_i=1, and on that transition shall load the target into cur_freq_o and increment the change count.
REQ-014 The timeout counter shall run in S_WAIT_UNLOCK and S_WAIT_LOCK; on reaching LOCK_TIMEOUT it shall set err_o, increment the timeout count, leave cur_freq_o unchanged and move to S_ACK.
REQ-015 S_ACK shall assert ack_o for exactly one cycle, then return to S_IDLE, or to S_CHECK if a request is pending.
REQ-016 Every accepted request shall produce exactly one ack_o pulse, whatever the outcome: clamped, unchanged, locked or timed out.
REQ-017 A req_en_i received outside S_IDLE shall be held in a single pending slot; a newer request shall overwrite an older pending one, and the overwritten request shall receive no ack.
REQ-018 A req_en_i arriving in the same cycle as ack_o shall be treated as pending.
REQ-019 err_o shall clear only on reset.
REQ-020 The statistics counters shall saturate at 16'hFFFF.

Reset
REQ-021 Asserting rst_n low shall asynchronously force:
- FSM to S_IDLE; pending slot empty; counters zero
- cur_freq_o=RESET_FREQ
- ack_o=0, cg_wr_o=0, busy_o=0, err_o=0
- cg_freq_o=RESET_FREQ
- stat_changes_o=0, stat_timeouts_o=0
REQ-022 Reset asserted mid-operation shall abandon the transaction without issuing ack_o.

Configuration
REQ-023 With macro DFS_ACTUATOR_STATS_EN defined, stat_changes_o and stat_timeouts_o shall count as specified in REQ-013, REQ-014 and REQ-020.
REQ-024 Without DFS_ACTUATOR_STATS_EN, both statistics outputs shall be constant zero, no counter logic shall be present, and all other behaviour shall be unchanged.

Verification
REQ-025 Request 400 with lock dropping one cycle after cg_wr_o and returning 10 cycles later -> one cg_wr_o with cg_freq_o=400, cur_freq_o=400, one ack_o, stat_changes_o=1.
REQ-026 Request 600 -> cg_freq_o=480; request 100 -> cg_freq_o=280; each request acked once.
REQ-027 Request 440 immediately after reset -> no cg_wr_o, ack_o within 3 cycles of req_en_i, stat_changes_o=0.
REQ-028 Request 320 with cg_locked_i held low -> err_o=1 after 1024 wait cycles, cur_freq_o unchanged, one ack_o, stat_timeouts_o=1.
REQ-029 Requests 360 then 380 during a busy transaction -> 360 dropped without ack, 380 applied and acked, two ack_o pulses in total.
REQ-030 rst_n pulsed low while in S_WAIT_LOCK -> no ack_o, cur_freq_o=440, busy_o=0 with no clock edge required.
